// File: rtl/serial_alu_seq_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// The requester side drives in_valid/op/a/b and out_ready. The sequencer side drives in_ready, out_valid, result and d.
interface serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             d;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, d
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, d
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial add/sub/OR/AND sequencer. Operands are processed LSB-first, one bit per clock.
// Latency: out_valid rises WIDTH cycles after the accept edge.
// Backpressure: DONE holds result/d until out_ready. No new request is accepted until the result is taken.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb, res;
    logic [1:0]       opr;
    logic             c, dreg;
    logic             ai, bi, r_bit, c_nxt, last;

    // One-bit ALU slice. c is carry for add and borrow for subtract.
    always_comb begin
        ai    = sa[0];
        bi    = sb[0];
        r_bit = 1'b0;
        c_nxt = 1'b0;
        case (opr)
            2'b00: begin
                r_bit = ai ^ bi ^ c;
                c_nxt = (ai & bi) | (c & (ai ^ bi));
            end
            2'b01: begin
                r_bit = ai ^ bi ^ c;
                c_nxt = (~ai & bi) | (c & ~(ai ^ bi));
            end
            2'b10:   r_bit = ai | bi;
            default: r_bit = ai & bi;
        endcase
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            opr  <= 2'b00;
            c    <= 1'b0;
            dreg <= 1'b0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sa  <= bus.a;
                        sb  <= bus.b;
                        opr <= bus.op;
                        c   <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    // Result fills from the MSB end, so after WIDTH shifts bit 0 is in place.
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= (res >> 1) | (WIDTH'(r_bit) << (WIDTH - 1));
                    c   <= c_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) dreg <= c_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = res;
    assign bus.d         = dreg;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq at WIDTH=8 and WIDTH=1.
// It uses directed vectors, a backpressure check, a mid-run reset check and random traffic against an arithmetic model.
module tb_serial_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc8 = -1;
    int   last_acc1 = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_alu_seq_if #(.WIDTH(8)) bus8 ();
    serial_alu_seq_if #(.WIDTH(1)) bus1 ();

    serial_alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_alu_seq #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       d;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^w.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input int w, output logic [31:0] r, output logic dd);
        logic [32:0] mask;
        logic [32:0] s;
        mask = (33'd1 << w) - 33'd1;
        r  = '0;
        dd = 1'b0;
        case (op)
            2'b00: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = 32'(s & mask);
                dd = ((s >> w) & 33'd1) != 33'd0;
            end
            2'b01: begin
                s  = {1'b0, a} - {1'b0, b};
                r  = 32'(s & mask);
                dd = (a < b);
            end
            2'b10:   r = a | b;
            default: r = a & b;
        endcase
    endfunction

    task automatic do8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit early, input int delay,
                       output logic [7:0] res, output logic dd, output int lat);
        int n;
        n = 0;
        while (!bus8.in_ready && n < 50) begin step(); n++; end
        if (!bus8.in_ready) check("in_ready_timeout8", {31'd0, bus8.in_ready}, 32'd1);
        bus8.op = op; bus8.a = a; bus8.b = b;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = early;
        step();
        if (last_acc8 >= 0) check("spacing8", {31'd0, (cyc - last_acc8) >= 10}, 32'd1);
        last_acc8 = cyc;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin step(); lat++; end
        res = bus8.result;
        dd  = bus8.d;
        if (!early) begin
            repeat (delay) step();
            bus8.out_ready = 1'b1;
        end
        step();
        bus8.out_ready = 1'b0;
    endtask

    task automatic do1(input logic [1:0] op, input logic a, input logic b,
                       input bit early, input int delay,
                       output logic res, output logic dd, output int lat);
        int n;
        n = 0;
        while (!bus1.in_ready && n < 50) begin step(); n++; end
        if (!bus1.in_ready) check("in_ready_timeout1", {31'd0, bus1.in_ready}, 32'd1);
        bus1.op = op; bus1.a = a; bus1.b = b;
        bus1.in_valid  = 1'b1;
        bus1.out_ready = early;
        step();
        if (last_acc1 >= 0) check("spacing1", {31'd0, (cyc - last_acc1) >= 3}, 32'd1);
        last_acc1 = cyc;
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 100) begin step(); lat++; end
        res = bus1.result[0];
        dd  = bus1.d;
        if (!early) begin
            repeat (delay) step();
            bus1.out_ready = 1'b1;
        end
        step();
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  res8;
        logic        rr1;
        logic        dd;
        logic [31:0] er;
        logic        ed;
        int          lat;

        vecs[0] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[1] = '{2'b00, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[2] = '{2'b01, 8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[3] = '{2'b01, 8'h05, 8'h03, 8'h02, 1'b0};
        vecs[4] = '{2'b01, 8'hA5, 8'hA5, 8'h00, 1'b0};
        vecs[5] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[6] = '{2'b11, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[7] = '{2'b10, 8'hF0, 8'h3C, 8'hFC, 1'b0};

        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.op = 2'b00; bus8.a = '0; bus8.b = '0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.op = 2'b00; bus1.a = '0; bus1.b = '0;

        step(); step();
        check("rst_in_ready",  {31'd0, bus8.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
        check("rst_result",    {24'd0, bus8.result},    32'd0);
        check("rst_d",         {31'd0, bus8.d},         32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do8(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1, res8, dd, lat);
            check($sformatf("vec%0d_res", i), {24'd0, res8}, {24'd0, vecs[i].res});
            check($sformatf("vec%0d_d", i),   {31'd0, dd},   {31'd0, vecs[i].d});
            check($sformatf("vec%0d_lat", i), lat, 8);
        end

        // Backpressure: hold DONE for 10 cycles while a competing request is offered.
        bus8.op = 2'b00; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin step(); lat++; end
        check("bp_lat", lat, 8);
        bus8.op = 2'b11; bus8.a = 8'h00; bus8.b = 8'h00; bus8.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("bp_out_valid", {31'd0, bus8.out_valid}, 32'd1);
            check("bp_result",    {24'd0, bus8.result},    32'd0);
            check("bp_d",         {31'd0, bus8.d},         32'd1);
            check("bp_in_ready",  {31'd0, bus8.in_ready},  32'd0);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        step();
        bus8.out_ready = 1'b0;
        check("bp_release_out_valid", {31'd0, bus8.out_valid}, 32'd0);
        check("bp_release_in_ready",  {31'd0, bus8.in_ready},  32'd1);
        step(); step();
        check("bp_no_phantom_job", {31'd0, bus8.in_ready}, 32'd1);
        last_acc8 = -1;

        // Reset after four bits of an add have been consumed.
        bus8.op = 2'b00; bus8.a = 8'h55; bus8.b = 8'h22; bus8.in_valid = 1'b1;
        step();
        bus8.in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  {31'd0, bus8.in_ready},  32'd1);
        check("mid_rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
        check("mid_rst_result",    {24'd0, bus8.result},    32'd0);
        check("mid_rst_d",         {31'd0, bus8.d},         32'd0);
        step();
        rst = 1'b0;
        lat = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus8.out_valid) lat++;
        end
        check("mid_rst_no_out_valid", lat, 0);
        last_acc8 = -1;
        last_acc1 = -1;
        do8(2'b00, 8'h01, 8'h01, 1'b0, 0, res8, dd, lat);
        check("post_rst_res", {24'd0, res8}, 32'h02);
        check("post_rst_d",   {31'd0, dd},   32'd0);
        check("post_rst_lat", lat, 8);

        // WIDTH=1 directed case: a single-bit borrow.
        do1(2'b01, 1'b0, 1'b1, 1'b0, 0, rr1, dd, lat);
        check("w1_sub_res", {31'd0, rr1}, 32'd1);
        check("w1_sub_d",   {31'd0, dd},  32'd1);
        check("w1_sub_lat", lat, 1);

        for (int n = 0; n < 1000; n++) begin
            logic [1:0] op;
            logic [7:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            do8(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), res8, dd, lat);
            model(op, {24'd0, a}, {24'd0, b}, 8, er, ed);
            check("rnd8_res", {24'd0, res8}, er);
            check("rnd8_d",   {31'd0, dd},   {31'd0, ed});
            check("rnd8_lat", lat, 8);
        end

        for (int n = 0; n < 1000; n++) begin
            logic [1:0] op;
            logic       a, b;
            op = 2'($urandom_range(0, 3));
            a  = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            do1(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), rr1, dd, lat);
            model(op, {31'd0, a}, {31'd0, b}, 1, er, ed);
            check("rnd1_res", {31'd0, rr1}, er);
            check("rnd1_d",   {31'd0, dd},  {31'd0, ed});
            check("rnd1_lat", lat, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Bit-serial arithmetic/logic sequencer: accepts two WIDTH-bit operands and a 2-bit opcode over a valid/ready handshake and processes them LSB-first, one bit per clock, through a single-bit add/subtract/OR/AND datapath with a registered carry/borrow. The result and final carry/borrow flag are returned over a second valid/ready handshake. It is the multi-bit driver of the team's 1-bit ALU operation set and uses the same opcode encoding and flag semantics.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- op  input  2  00 add, 01 subtract (a-b), 10 OR, 11 AND; sampled on accept.
- a  input  WIDTH  operand A; sampled on accept.
- b  input  WIDTH  operand B; sampled on accept.
- out_valid  output  1  result/d valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  computed result.
- d  output  1  add: carry out of MSB; sub: borrow out of MSB (1 when a<b unsigned); OR/AND: 0.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: in_ready=1, out_valid=0, result=0, d=0; bit counter, carry/borrow register, operand shift registers cleared.
- IDLE: in_ready=1. Accept = in_valid & in_ready. On accept: latch a, b, op; clear carry/borrow register c; counter=0; go RUN.
- RUN: in_ready=0, out_valid=0. Each cycle consume bit i (a_i, b_i = LSBs of shift registers):
  - add: r_i = a_i^b_i^c; c_next = (a_i&b_i) | (c&(a_i^b_i)).
  - sub: r_i = a_i^b_i^c; c_next = (~a_i&b_i) | (c&~(a_i^b_i)).
  - OR: r_i = a_i|b_i; c held 0. AND: r_i = a_i&b_i; c held 0.
  - r_i shifted into result from the MSB end (result shifts right), operands shift right; counter increments.
  - After the WIDTH-th bit: d <= c_next (0 for OR/AND); go DONE.
- DONE: out_valid=1, in_ready=0; result and d held stable. On out_ready: out_valid drops, go IDLE.
- result/d are not cleared on leaving DONE; they keep last values until the next RUN overwrites result and the next completion overwrites d. Consumers qualify with out_valid only.
- op, a, b changes outside the accept cycle have no effect.
- Arithmetic modulo 2^WIDTH; no signed interpretation; no overflow flag.

## Timing
- Accept at rising edge T0 (IDLE, in_valid=1). RUN occupies edges T1..TWIDTH; out_valid=1 from just after edge TWIDTH.
- Latency accept-edge to out_valid: WIDTH cycles.
- Handshake complete at first edge with out_valid & out_ready; in_ready=1 the following cycle. Minimum request spacing WIDTH+2 cycles; no overlap of requests.
- out_ready held high before DONE: result consumed on the first DONE cycle (1-cycle out_valid pulse).
- out_ready low: DONE held indefinitely, outputs stable.
- in_valid during RUN/DONE ignored (in_ready=0); requester must hold it until accepted.
- rst asserted in any state (including mid-RUN): immediate return to reset values, partial result discarded, no out_valid produced; first accept possible on the first edge after rst deasserts.
- WIDTH=1: RUN lasts one cycle; d = carry/borrow of the single bit.

## Test plan
- Add, WIDTH=8: a=8'hFF, b=8'h01, op=00 -> result=8'h00, d=1, out_valid exactly 8 cycles after accept; a=8'h12, b=8'h34 -> 8'h46, d=0.
- Subtract: a=8'h03, b=8'h05, op=01 -> result=8'hFE, d=1; a=8'h05, b=8'h03 -> 8'h02, d=0; a=b=8'hA5 -> 8'h00, d=0.
- Logic: a=8'hF0, b=8'h3C; op=10 -> 8'hFC, d=0; op=11 -> 8'h30, d=0 (after a prior add leaving d=1).
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, result, d stable, in_ready=0, new in_valid ignored; out_ready=1 -> accepted, in_ready=1 next cycle.
- Reset mid-RUN: assert rst at bit 4 of an add -> outputs at reset values immediately, no out_valid; subsequent request a=8'h01, b=8'h01, op=00 -> 8'h02, d=0.
- Random: 1000 back-to-back requests, WIDTH=8 and WIDTH=1, random op/a/b and random out_ready -> result/d match reference model; spacing >= WIDTH+2.
